// File: rtl/bp_trace_pkg.sv
// Shared types and constants for the branch-trace replay driver.
package bp_trace_pkg;

  localparam int unsigned ID_W      = 3;
  localparam int unsigned CLEAR_LEN = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            outcome;
  } trace_entry_t;

endpackage

// File: rtl/branch_trace_ram.sv
// Trace storage: one loader write port, one synchronous read port.
module branch_trace_ram
  import bp_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_entry_t             rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/branch_trace_driver.sv
// Replays a stored (branch ID, outcome) trace into a predictor, clearing it
// first, and counts the mispredictions it reports one cycle after each entry.
module branch_trace_driver #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ID_W  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_we,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [ID_W-1:0]            load_id,
  input  logic                       load_outcome,
  input  logic [$clog2(DEPTH):0]     trace_len,
  input  logic                       start,
  output logic [ID_W-1:0]            branchID,
  output logic                       outcome,
  output logic                       bp_reset,
  input  logic                       miss,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           miss_count,
  output logic [CNT_W-1:0]           branch_count
);

  import bp_trace_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_t          state, state_nxt;
  logic [1:0]      clr_cnt;
  logic [AW-1:0]   fptr;
  logic [LW-1:0]   idx, len;
  logic            valid;
  logic            fetch;
  logic            accept_start;
  trace_entry_t    wdata, rdata;

  logic [ID_W-1:0] branch_id_nxt;
  logic            outcome_nxt, bp_reset_nxt, busy_nxt, done_nxt;

  assign wdata = '{id: load_id, outcome: load_outcome};

  branch_trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (load_we & ~busy),
    .waddr (load_addr),
    .wdata (wdata),
    .raddr (fptr),
    .rdata (rdata)
  );

  // Next state, and registered outputs derived from the state being entered
  always_comb begin
    state_nxt     = state;
    branch_id_nxt = '0;
    outcome_nxt   = 1'b0;
    accept_start  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt    = S_CLEAR;
          accept_start = 1'b1;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == 2'(CLEAR_LEN - 1)) state_nxt = (len == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (idx == len - LW'(1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    bp_reset_nxt = (state_nxt == S_CLEAR);
    busy_nxt     = (state_nxt == S_CLEAR) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
    done_nxt     = (state_nxt == S_DONE);
    if (state_nxt == S_RUN) begin
      branch_id_nxt = ID_W'(rdata.id);
      outcome_nxt   = rdata.outcome;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      branchID <= '0;
      outcome  <= 1'b0;
      bp_reset <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      branchID <= branch_id_nxt;
      outcome  <= outcome_nxt;
      bp_reset <= bp_reset_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Read address runs two entries ahead of the driven entry: RAM latency plus output register
  assign fetch = ((state == S_CLEAR) && (clr_cnt >= 2'(CLEAR_LEN - 2))) || (state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt      <= '0;
      fptr         <= '0;
      idx          <= '0;
      len          <= '0;
      valid        <= 1'b0;
      miss_count   <= '0;
      branch_count <= '0;
    end else begin
      valid <= (state == S_RUN);
      if (accept_start) begin
        len          <= trace_len;
        clr_cnt      <= '0;
        fptr         <= '0;
        idx          <= '0;
        miss_count   <= '0;
        branch_count <= '0;
      end else begin
        if (state == S_CLEAR) clr_cnt <= clr_cnt + 2'd1;
        if (fetch) fptr <= fptr + AW'(1);
        if (state == S_RUN) idx <= idx + LW'(1);
        if (valid) begin
          branch_count <= branch_count + CNT_W'(1);
          miss_count   <= miss_count + CNT_W'(miss);
        end
      end
    end
  end

endmodule
